sysid_checker: RTL
==================

Name: sysid_checker

Overview:
- Avalon-MM read master that sits directly downstream of the system-ID slave and consumes its readdata.
- On a start pulse it reads word 0 (system ID) and word 1 (timestamp), compares both against expected values, and reports pass/fail/timeout.
- Boot-time integrity monitor. Its flags feed the status register block and the CPU reset-release logic.

Parameters:
- EXPECTED_ID, 32'h5147_0A19, system ID value required at address 0.
- EXPECTED_TS, 32'h0000_0000, timestamp required at address 1; ignored when CHECK_TS=0.
- CHECK_TS, 1, 1 = timestamp must match; 0 = timestamp is captured only.
- TIMEOUT, 16, max cycles m_read may be held under m_waitrequest per access (1..255).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to run a check
- m_address  out  1  Avalon word address to sysid slave (0=ID, 1=timestamp)
- m_read  out  1  Avalon read strobe
- m_readdata  in  32  Avalon read data (valid in the cycle m_read=1 and m_waitrequest=0)
- m_waitrequest  in  1  slave stall
- busy  out  1  check in progress
- done  out  1  one-cycle pulse when a check finishes (any outcome)
- id_ok  out  1  captured ID equals EXPECTED_ID (sticky until next start)
- ts_ok  out  1  timestamp check passed (forced 1 when CHECK_TS=0)
- timeout  out  1  an access exceeded TIMEOUT (sticky until next start)
- id_value  out  32  last captured ID word
- ts_value  out  32  last captured timestamp word

Behaviour:
- Reset, synchronous, active-high:
  - State = IDLE.
  - m_read=0, m_address=0, busy=0, done=0.
  - id_ok=0, ts_ok=0, timeout=0.
  - id_value=0, ts_value=0, timeout counter=0.
  - Reset asserted mid-transfer drops m_read at that same edge. No partial results are kept.
- All outputs are registered.
- States: IDLE, RD_ID, RD_TS, EVAL.
- IDLE:
  - start=1 -> RD_ID next cycle.
  - At the same edge, clear id_ok/ts_ok/timeout, set busy=1, m_read=1, m_address=0, counter=0.
  - id_value/ts_value keep their old contents until overwritten.
- RD_ID:
  - m_read held at 1 and m_address stable while m_waitrequest=1.
  - Cycle with m_waitrequest=0: id_value<=m_readdata; next state RD_TS with m_address=1, m_read stays 1, counter=0.
  - Back-to-back accesses: no idle cycle between ID and TS reads.
- RD_TS: same handshake. On accept, ts_value<=m_readdata, m_read<=0, next state EVAL.
- EVAL, one cycle:
  - id_ok<=(id_value==EXPECTED_ID).
  - ts_ok<=(CHECK_TS==0) || (ts_value==EXPECTED_TS).
  - done<=1 for one cycle; busy<=0; -> IDLE.
  - Flags update on the same edge as the done pulse.
- Timeout:
  - The counter increments each cycle m_read=1 && m_waitrequest=1.
  - When counter==TIMEOUT-1 and the slave still stalls: m_read<=0, timeout<=1, id_ok<=0, ts_ok<=0, done pulse, busy<=0 -> IDLE.
  - The value captured for the aborted access is not written.
  - m_waitrequest dropping in the same cycle the limit is hit counts as success, not timeout.
- Zero-wait slave: minimum check is 4 cycles from start edge to done pulse (RD_ID 1, RD_TS 1, EVAL 1, done asserted on the EVAL exit edge).
- start while busy=1 is ignored. No queueing.
- start in the same cycle as done is accepted (new check begins).
- start and reset together: reset wins.

Test Plan:
- Zero-wait slave returns 32'h5147_0A19 then 32'h0000_0000; pulse start -> m_read high 2 cycles (addr 0 then 1), done 4 cycles after start edge, id_ok=1, ts_ok=1, timeout=0, id_value=32'h5147_0A19.
- Slave returns ID 32'h5147_0A18 -> done pulse, id_ok=0, id_value=32'h5147_0A18. Rerun with correct ID -> id_ok=1 (flags cleared at start).
- m_waitrequest held 3 cycles on each access -> m_read/m_address stable during stall, data captured only on release, done 10 cycles after start, id_ok=1.
- m_waitrequest stuck high, TIMEOUT=16 -> m_read drops after 16 stall cycles, timeout=1, id_ok=0, ts_ok=0, single done pulse, busy=0. Edge case: waitrequest releases on the 16th cycle -> no timeout.
- CHECK_TS=0, timestamp 32'hDEAD_BEEF -> ts_ok=1, ts_value=32'hDEAD_BEEF. start pulsed while busy -> ignored, exactly one done.
- reset asserted during RD_TS stall -> next edge m_read=0, busy=0, all flags/values 0. No done pulse. New start runs normally.

Source files
------------

// File: rtl/sysid_checker.sv
// sysid_checker: boot-time integrity monitor for the system-ID slave.
// On a start pulse it issues two Avalon-MM reads (word 0 = system ID,
// word 1 = timestamp), compares the words with the expected values and
// reports pass/fail/timeout through registered, sticky flags.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID = 32'h5147_0A19,
  parameter logic [31:0] EXPECTED_TS = 32'h0000_0000,
  parameter bit          CHECK_TS    = 1'b1,
  parameter int          TIMEOUT     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  // Last stall count tolerated; a stall seen while the counter sits here aborts.
  localparam logic [7:0] LAST_STALL = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    EVAL  = 2'd3
  } state_t;

  state_t     state_reg;
  logic [7:0] stall_cnt_reg;
  logic       stall_expired;

  // The current access has stalled for the full budget and is still stalled.
  assign stall_expired = m_waitrequest && (stall_cnt_reg == LAST_STALL);

  // Check sequencer: issues both reads back to back, then evaluates the captures.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      stall_cnt_reg <= 8'd0;
      m_read        <= 1'b0;
      m_address     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      id_ok         <= 1'b0;
      ts_ok         <= 1'b0;
      timeout       <= 1'b0;
      id_value      <= 32'd0;
      ts_value      <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg     <= RD_ID;
            stall_cnt_reg <= 8'd0;
            m_read        <= 1'b1;
            m_address     <= 1'b0;
            busy          <= 1'b1;
            id_ok         <= 1'b0;
            ts_ok         <= 1'b0;
            timeout       <= 1'b0;
          end
        end

        RD_ID: begin
          if (!m_waitrequest) begin
            // ID accepted; go straight on to the timestamp with no idle cycle.
            id_value      <= m_readdata;
            m_address     <= 1'b1;
            stall_cnt_reg <= 8'd0;
            state_reg     <= RD_TS;
          end else if (stall_expired) begin
            m_read    <= 1'b0;
            timeout   <= 1'b1;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else begin
            stall_cnt_reg <= stall_cnt_reg + 8'd1;
          end
        end

        RD_TS: begin
          if (!m_waitrequest) begin
            ts_value  <= m_readdata;
            m_read    <= 1'b0;
            state_reg <= EVAL;
          end else if (stall_expired) begin
            m_read    <= 1'b0;
            timeout   <= 1'b1;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else begin
            stall_cnt_reg <= stall_cnt_reg + 8'd1;
          end
        end

        EVAL: begin
          // Flags are published on the same edge as the done pulse.
          id_ok     <= (id_value == EXPECTED_ID);
          ts_ok     <= (!CHECK_TS) || (ts_value == EXPECTED_TS);
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
